// File: rtl/adder_pkg.sv
// adder_pkg: shared lookahead group width for the adder32 carry-lookahead datapath
package adder_pkg;
    localparam int GROUP_W = 4;
endpackage

// File: rtl/cla4.sv
// cla4: 4-bit lookahead group; in a[3:0],b[3:0],ci; out s[3:0], group propagate p_o, group generate g_o
module cla4
    import adder_pkg::*;
(
    input  logic [GROUP_W-1:0] a,
    input  logic [GROUP_W-1:0] b,
    input  logic               ci,
    output logic [GROUP_W-1:0] s,
    output logic               p_o,
    output logic               g_o
);
    logic [3:0] p, g, c;
    always_comb begin
        p = a ^ b;
        g = a & b;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        s = p ^ c;
        p_o = &p;
        g_o = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    end
endmodule

// File: rtl/adder32.sv
// adder32: registered {cout,sum}=a+b+cin CLA adder; in clk,rst,a,b,cin; out sum,cout (1-cycle latency)
module adder32
    import adder_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int N = WIDTH / GROUP_W;
    logic [N-1:0]     gp, gg;
    logic [N:0]       gc;
    logic [WIDTH-1:0] sum_d, sum_q;
    logic             cout_d, cout_q, c, t;
    for (genvar i = 0; i < N; i++) begin : g_grp
        cla4 u_cla4 (
            .a  (a[i*GROUP_W +: GROUP_W]),
            .b  (b[i*GROUP_W +: GROUP_W]),
            .ci (gc[i]),
            .s  (sum_d[i*GROUP_W +: GROUP_W]),
            .p_o(gp[i]),
            .g_o(gg[i])
        );
    end
    // Each group carry is a flat sum-of-products of group P/G and cin, not a ripple chain.
    always_comb begin
        gc = '0;
        c = 1'b0;
        t = 1'b0;
        for (int i = 0; i <= N; i++) begin
            c = cin;
            for (int j = 0; j < i; j++) c = c & gp[j];
            for (int j = 0; j < i; j++) begin
                t = gg[j];
                for (int k = j + 1; k < i; k++) t = t & gp[k];
                c = c | t;
            end
            gc[i] = c;
        end
        cout_d = gc[N];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end
    assign sum  = sum_q;
    assign cout = cout_q;
endmodule

// File: tb/tb_adder32.sv
// tb_adder32: randomized self-checking bench for adder32 against an arithmetic model
module tb_adder32;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] a = '0, b = '0;
    logic        cin = 1'b0;
    logic [31:0] sum;
    logic        cout;
    int          checks = 0;
    int          errors = 0;

    adder32 #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b),
        .cin (cin),
        .sum (sum),
        .cout(cout)
    );

    always #5 clk = ~clk;

    function automatic logic [32:0] model(input logic [31:0] x, input logic [31:0] y, input logic ci);
        longint unsigned r;
        r = longint'(x) + longint'(y) + longint'(ci);
        return r[32:0];
    endfunction

    task automatic drive(input logic [31:0] x, input logic [31:0] y, input logic ci);
        a = x;
        b = y;
        cin = ci;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst = 1'b1;
        drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({cout, sum} !== 33'h0) begin
                errors++;
                $display("FAIL reset[%0d] got cout=%0b sum=%h want cout=0 sum=00000000", i, cout, sum);
            end
        end
    endtask

    task automatic test_carry_ripple;
        rst = 1'b0;
        drive(32'hFFFF_FFFF, 32'h0, 1'b1);
        @(negedge clk);
        checks++;
        if ({cout, sum} !== {1'b1, 32'h0}) begin
            errors++;
            $display("FAIL carry_ripple got cout=%0b sum=%h want cout=1 sum=00000000", cout, sum);
        end
    endtask

    task automatic test_boundaries;
        drive(32'h7FFF_FFFF, 32'h1, 1'b0);
        @(negedge clk);
        checks++;
        if ({cout, sum} !== {1'b0, 32'h8000_0000}) begin
            errors++;
            $display("FAIL half_boundary got cout=%0b sum=%h want cout=0 sum=80000000", cout, sum);
        end
        drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        @(negedge clk);
        checks++;
        if ({cout, sum} !== {1'b1, 32'hFFFF_FFFF}) begin
            errors++;
            $display("FAIL max_sum got cout=%0b sum=%h want cout=1 sum=ffffffff", cout, sum);
        end
    endtask

    task automatic test_back_to_back;
        drive(32'h1, 32'h2, 1'b0);
        @(negedge clk);
        checks++;
        if ({cout, sum} !== 33'h3) begin
            errors++;
            $display("FAIL b2b_first got cout=%0b sum=%h want cout=0 sum=00000003", cout, sum);
        end
        drive(32'h10, 32'h20, 1'b1);
        @(negedge clk);
        checks++;
        if ({cout, sum} !== 33'h31) begin
            errors++;
            $display("FAIL b2b_second got cout=%0b sum=%h want cout=0 sum=00000031", cout, sum);
        end
    endtask

    task automatic test_random(input int n);
        logic [32:0] exp;
        logic [31:0] x, y;
        logic        ci;
        for (int i = 0; i < n; i++) begin
            x = $urandom;
            y = $urandom;
            ci = 1'($urandom_range(1));
            if (i % 8 == 0) y = ~x;
            drive(x, y, ci);
            exp = model(x, y, ci);
            @(negedge clk);
            checks++;
            if ({cout, sum} !== exp) begin
                errors++;
                $display("FAIL random[%0d] a=%h b=%h cin=%0b got cout=%0b sum=%h want cout=%0b sum=%h",
                         i, x, y, ci, cout, sum, exp[32], exp[31:0]);
            end
        end
    endtask

    task automatic test_reset_mid_stream;
        logic [32:0] exp;
        logic [31:0] x, y;
        test_random(20);
        rst = 1'b1;
        drive($urandom, $urandom, 1'b1);
        @(negedge clk);
        checks++;
        if ({cout, sum} !== 33'h0) begin
            errors++;
            $display("FAIL mid_reset got cout=%0b sum=%h want cout=0 sum=00000000", cout, sum);
        end
        rst = 1'b0;
        x = $urandom | 32'h8000_0000;
        y = $urandom | 32'h8000_0000;
        drive(x, y, 1'b0);
        exp = model(x, y, 1'b0);
        @(negedge clk);
        checks++;
        if ({cout, sum} !== exp) begin
            errors++;
            $display("FAIL post_reset got cout=%0b sum=%h want cout=%0b sum=%h", cout, sum, exp[32], exp[31:0]);
        end
        test_random(30);
    endtask

    initial begin
        void'($urandom(32'd2024));
        test_reset;
        test_carry_ripple;
        test_boundaries;
        test_back_to_back;
        test_random(100);
        test_reset_mid_stream;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
